wb_unit: RTL and testbench

WB_UNIT -- requirements
Module: wb_unit

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/load_align.sv | 51 +++++
 rtl/wb_unit.sv | 119 +++++++++++
 tb/tb_wb_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, load-type codes and the
// writeback FSM state encoding used by the writeback unit.
package cpu_pkg;

  // Default datapath and register-address widths.
  localparam int CPU_DATA_WIDTH = 32;
  localparam int CPU_ADDR_WIDTH = 5;

  // Load kinds carried with a load request. Any other code is a full word.
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LW  = 3'b100;

  // Writeback FSM encoding.
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_WAIT_MEM = 2'b01;
  localparam logic [1:0] ST_WRITE    = 2'b10;

  // Pending-load context held while the unit waits for memory data.
  typedef struct packed {
    logic [2:0] ld_type;
    logic [1:0] byte_off;
  } load_ctx_t;

  // True for the load kinds whose result is sign-extended.
  function automatic logic ld_is_signed(input logic [2:0] ld_type);
    return (ld_type == LD_LB) || (ld_type == LD_LH);
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte or halfword out of the
// memory word and sign- or zero-extends it; other codes pass the word.
module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [2:0]            ld_type,
  input  logic [1:0]            byte_off,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        ext_bit_byte;
  logic        ext_bit_half;

  // Select the byte lane addressed by the low address bits.
  always_comb begin
    sel_byte = word[7:0];
    case (byte_off)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
  end

  // Halfword lane uses only the upper offset bit; misaligned bit 0 is ignored.
  always_comb begin
    sel_half = byte_off[1] ? word[31:16] : word[15:0];
  end

  // Fill bit is the lane's top bit for signed kinds and zero otherwise.
  always_comb begin
    ext_bit_byte = ld_is_signed(ld_type) & sel_byte[7];
    ext_bit_half = ld_is_signed(ld_type) & sel_half[15];
  end

  // Assemble the extended result for the requested load kind.
  always_comb begin
    data = word;
    case (ld_type)
      LD_LB, LD_LBU: data = {{(DATA_WIDTH-8){ext_bit_byte}}, sel_byte};
      LD_LH, LD_LHU: data = {{(DATA_WIDTH-16){ext_bit_half}}, sel_half};
      default:       data = word;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: accepts one ALU or load result at a time, waits for
// memory data on loads, and issues a single registered register-file write.
module wb_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int ADDR_WIDTH = CPU_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_waddr,
  input  logic                  in_is_load,
  input  logic [2:0]            in_ld_type,
  input  logic [1:0]            in_byte_off,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  busy
);

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic                  accept;
  logic                  load_done;
  logic [ADDR_WIDTH-1:0] pend_waddr;
  load_ctx_t             pend_ctx;
  logic [DATA_WIDTH-1:0] load_data;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = in_valid & in_ready;
  assign load_done = (state == ST_WAIT_MEM) & mem_rvalid;

  load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .word     (mem_rdata),
    .ld_type  (pend_ctx.ld_type),
    .byte_off (pend_ctx.byte_off),
    .data     (load_data)
  );

  // Next-state rules: memory data only matters while waiting for it.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = in_is_load ? ST_WAIT_MEM : ST_WRITE;
        end
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid) begin
          next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Hold the destination and load context until memory data arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_waddr <= '0;
      pend_ctx   <= '0;
    end else if (accept && in_is_load) begin
      pend_waddr        <= in_waddr;
      pend_ctx.ld_type  <= in_ld_type;
      pend_ctx.byte_off <= in_byte_off;
    end
  end

  // Write strobe is high exactly for the WRITE cycle, never for register 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen <= 1'b0;
    end else if (accept && !in_is_load) begin
      rf_wen <= (in_waddr != '0);
    end else if (load_done) begin
      rf_wen <= (pend_waddr != '0);
    end else begin
      rf_wen <= 1'b0;
    end
  end

  // Write address and data are loaded as the unit enters WRITE and then held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (accept && !in_is_load) begin
      rf_waddr <= in_waddr;
      rf_wdata <= in_alu_result;
    end else if (load_done) begin
      rf_waddr <= pend_waddr;
      rf_wdata <= load_data;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Testbench for wb_unit: directed scenarios plus randomized ALU/load traffic
// checked against an arithmetic reference for load extension.
module tb_wb_unit;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_waddr;
  logic          in_is_load;
  logic [2:0]    in_ld_type;
  logic [1:0]    in_byte_off;
  logic [DW-1:0] in_alu_result;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;

  int assert_count = 0;
  int fail_count   = 0;

  wb_unit #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_waddr      (in_waddr),
    .in_is_load    (in_is_load),
    .in_ld_type    (in_ld_type),
    .in_byte_off   (in_byte_off),
    .in_alu_result (in_alu_result),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .rf_wen        (rf_wen),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .busy          (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference load result from plain arithmetic on the memory word.
  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] off,
                                           input logic [31:0] w);
    longint b;
    longint h;
    longint v;
    b = longint'((w >> (8 * int'(off))) % 256);
    h = longint'((w >> (16 * (int'(off) / 2))) % 65536);
    case (t)
      3'd0:    v = (b >= 128) ? b - 256 : b;
      3'd1:    v = b;
      3'd2:    v = (h >= 32768) ? h - 65536 : h;
      3'd3:    v = h;
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, ".rf_wen"}, 32'(rf_wen), 32'd0);
    check_output({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check_output({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // One ALU request from IDLE through WRITE and back to IDLE.
  task automatic apply_alu(input logic [AW-1:0] wa, input logic [31:0] alu, input string tag);
    in_valid      = 1'b1;
    in_is_load    = 1'b0;
    in_waddr      = wa;
    in_alu_result = alu;
    in_ld_type    = 3'($urandom);
    in_byte_off   = 2'($urandom);
    check_output({tag, ".ready_at_accept"}, 32'(in_ready), 32'd1);
    step();
    in_valid      = 1'b0;
    in_waddr      = AW'($urandom);
    in_alu_result = $urandom;
    check_output({tag, ".rf_wen"}, 32'(rf_wen), 32'(wa != 0));
    if (wa != 0) begin
      check_output({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(wa));
      check_output({tag, ".rf_wdata"}, rf_wdata, alu);
    end
    check_output({tag, ".ready_in_write"}, 32'(in_ready), 32'd0);
    check_output({tag, ".busy_in_write"}, 32'(busy), 32'd1);
    step();
    check_idle({tag, ".after"});
  endtask

  // One load request: optional stray rvalid in IDLE, accept and WRITE cycles.
  task automatic apply_load(input logic [AW-1:0] wa, input logic [2:0] t, input logic [1:0] off,
                            input logic [31:0] word, input int waits, input logic stray,
                            input logic [31:0] expected, input string tag);
    if (stray) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      step();
      check_idle({tag, ".stray_idle"});
    end
    in_valid      = 1'b1;
    in_is_load    = 1'b1;
    in_waddr      = wa;
    in_ld_type    = t;
    in_byte_off   = off;
    in_alu_result = $urandom;
    mem_rvalid    = stray;
    mem_rdata     = $urandom;
    check_output({tag, ".ready_at_accept"}, 32'(in_ready), 32'd1);
    step();
    in_valid    = 1'b0;
    in_waddr    = AW'($urandom);
    in_ld_type  = 3'($urandom);
    in_byte_off = 2'($urandom);
    mem_rvalid  = 1'b0;
    mem_rdata   = $urandom;
    for (int i = 0; i < waits; i++) begin
      check_output({tag, ".wait_wen"}, 32'(rf_wen), 32'd0);
      check_output({tag, ".wait_busy"}, 32'(busy), 32'd1);
      check_output({tag, ".wait_ready"}, 32'(in_ready), 32'd0);
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    step();
    mem_rvalid = stray;
    mem_rdata  = $urandom;
    check_output({tag, ".rf_wen"}, 32'(rf_wen), 32'(wa != 0));
    if (wa != 0) begin
      check_output({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(wa));
      check_output({tag, ".rf_wdata"}, rf_wdata, expected);
    end
    check_output({tag, ".busy_in_write"}, 32'(busy), 32'd1);
    step();
    mem_rvalid = 1'b0;
    check_idle({tag, ".after"});
  endtask

  initial begin
    logic [AW-1:0] wa;
    logic [2:0]    t;
    logic [1:0]    off;
    logic [31:0]   w;

    // Reset with a request already waiting at the input.
    rst           = 1'b0;
    in_valid      = 1'b1;
    in_is_load    = 1'b0;
    in_waddr      = 5'd7;
    in_ld_type    = 3'd0;
    in_byte_off   = 2'd0;
    in_alu_result = 32'hCAFE0001;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    #12;
    check_output("reset.rf_wen", 32'(rf_wen), 32'd0);
    check_output("reset.rf_waddr", 32'(rf_waddr), 32'd0);
    check_output("reset.rf_wdata", rf_wdata, 32'd0);
    check_idle("reset");
    #8;
    rst = 1'b1;
    #1;
    check_output("release.busy_before_edge", 32'(busy), 32'd0);
    step();
    in_valid = 1'b0;
    check_output("release.first_accept_wen", 32'(rf_wen), 32'd1);
    check_output("release.first_accept_wdata", rf_wdata, 32'hCAFE0001);
    step();
    check_idle("release.after");

    // Directed ALU, back-to-back ALU, and register-0 guard.
    apply_alu(5'd5, 32'h12345678, "alu_basic");
    apply_alu(5'd31, 32'hA5A5A5A5, "alu_b2b");
    apply_alu(5'd0, 32'hFFFFFFFF, "alu_x0");

    // Directed byte and halfword loads.
    apply_load(5'd3, 3'b000, 2'd2, 32'h00800000, 3, 1'b0, 32'hFFFFFF80, "lb_off2");
    apply_load(5'd4, 3'b001, 2'd2, 32'h00800000, 3, 1'b0, 32'h00000080, "lbu_off2");
    apply_load(5'd6, 3'b010, 2'd3, 32'h8001FFFF, 1, 1'b0, 32'hFFFF8001, "lh_off3");
    apply_load(5'd8, 3'b011, 2'd0, 32'h1234ABCD, 0, 1'b0, 32'h0000ABCD, "lhu_off0");
    apply_load(5'd9, 3'b111, 2'd3, 32'h87654321, 2, 1'b0, 32'h87654321, "ld_code7");

    // Stray rvalid in IDLE and in the accept cycle, later word wins.
    apply_load(5'd10, 3'b100, 2'd1, 32'hDEADBEEF, 2, 1'b1, 32'hDEADBEEF, "stray");

    // Reset while waiting for memory: request dropped.
    in_valid    = 1'b1;
    in_is_load  = 1'b1;
    in_waddr    = 5'd12;
    in_ld_type  = 3'b100;
    in_byte_off = 2'd0;
    step();
    in_valid = 1'b0;
    step();
    check_output("rst_load.busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_idle("rst_load.during");
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11112222;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("rst_load.after");
    end
    mem_rvalid = 1'b0;

    // Reset while in WRITE clears the strobe at once.
    in_valid      = 1'b1;
    in_is_load    = 1'b0;
    in_waddr      = 5'd13;
    in_alu_result = 32'h0BADF00D;
    step();
    in_valid = 1'b0;
    check_output("rst_write.wen_pre", 32'(rf_wen), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_write.rf_wen", 32'(rf_wen), 32'd0);
    check_output("rst_write.rf_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check_idle("rst_write.after");

    // Randomized mix of ALU and load requests.
    for (int n = 0; n < 40; n++) begin
      wa = AW'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        apply_alu(wa, $urandom, "rand_alu");
      end else begin
        t   = 3'($urandom);
        off = 2'($urandom);
        w   = $urandom;
        apply_load(wa, t, off, w, int'($urandom_range(0, 3)), 1'($urandom), ref_load(t, off, w),
                   "rand_load");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
